mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
MEM-stage data-memory sequencer for the pipelined LC-3b. It turns the load/store instruction held in the MEM stage (LDB, LDW, LDI, STB, STW, STI) into one or two data-memory transactions. It aligns and merges byte data and returns the load result. It drives memstall, which the EX-stage leap-frog/stall logic consumes; the MEM-stage opcode, address and store data are guaranteed stable while memstall is high.

Parameters:
- DATA_WIDTH, 16, data and address width; the block supports only 16.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  MEM stage holds a valid (non-bubble) instruction
- mem_opcode  in  lc3b_opcode  opcode of the MEM-stage instruction
- mem_addr  in  16  effective address computed in EX
- mem_sdata  in  16  store source-register value
- wb_load  in  1  MEM/WB pipeline register loads this cycle
- dmem_resp  in  1  data memory completes the current access (1-cycle pulse)
- dmem_rdata  in  16  read data, valid when dmem_resp=1
- dmem_read  out  1  read request, level, held until dmem_resp
- dmem_write  out  1  write request, level, held until dmem_resp
- dmem_address  out  16  access address
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  byte lanes {hi,lo}
- memstall  out  1  MEM stage cannot advance
- load_data  out  16  final load value for WB

Behaviour:
- mem_op = mem_valid & opcode ∈ {ldb, ldw, ldi, stb, stw, sti}. Indirect = ldi or sti.
- States: IDLE, ACC1, ACC2, DONE. State, ptr_reg (16) and load_data_reg (16) are registered.
- Reset: state=IDLE, ptr_reg=0, load_data=0. Outputs: dmem_read=0, dmem_write=0, memstall=0. Reset mid-access abandons the access; a late dmem_resp in IDLE is ignored.
- IDLE:
  - mem_op=1 → ACC1. memstall=1 combinationally in the same cycle.
  - otherwise stay in IDLE; memstall=0.
- ACC1:
  - Request type: read for loads and for indirect ops; write for stb/stw.
  - Address: word ops and indirect ops use {mem_addr[15:1],0}, byte_enable=2'b11. Byte ops use mem_addr, byte_enable = mem_addr[0] ? 2'b10 : 2'b01.
  - On dmem_resp: if indirect, ptr_reg ← dmem_rdata and go to ACC2; otherwise capture load data and go to DONE.
- ACC2:
  - ldi reads at {ptr_reg[15:1],0}; sti writes at {ptr_reg[15:1],0}. byte_enable=2'b11.
  - On dmem_resp → DONE; ldi captures dmem_rdata.
- Write data:
  - stw/sti: dmem_wdata = mem_sdata.
  - stb: dmem_wdata = {mem_sdata[7:0], mem_sdata[7:0]}.
- Load capture:
  - ldw/ldi: load_data = dmem_rdata.
  - ldb: selected byte (hi if mem_addr[0]) sign-extended to 16 bits.
- DONE: memstall=0 and no request is driven. wb_load=1 → IDLE; otherwise hold DONE, which covers stalls from other stages.
- memstall = mem_op & (state≠DONE).
- Latency, counted from mem_op first seen to memstall low (responses of N cycles): 1+N for single-access ops, 1+2N for indirect ops. The minimum with N=1 is 2 and 3 cycles.
- mem_valid dropping in ACC1/ACC2 (flush): finish the in-flight access (the bus protocol requires it), then return to IDLE and do not start ACC2.
- The request is never asserted in IDLE or DONE. read and write are never asserted together.

Decomposition:
- lc3b_types package holds lc3b_opcode and its op_* constants, plus a new mem_ctrl_state_t enum.
- Byte-lane logic is a combinational sub-module, byte_lane_align: store replication, byte-enable generation, and LDB byte select with sign extension.
- The FSM and registers stay in mem_access_ctrl.

Test Plan:
- LDW, addr=0x3001, rdata=0xBEEF, resp after 2 cycles → dmem_address=0x3000, be=11, memstall high for 3 cycles, load_data=0xBEEF.
- LDB, addr=0x4001, rdata=0x80AA → be=10, load_data=0xFF80. LDB, addr=0x4000, rdata=0x807F → load_data=0x007F.
- STB, addr=0x5001, sdata=0x1234 → dmem_write, wdata=0x3434, be=10, one access only.
- LDI, addr=0x6000, first rdata=0x7003, second rdata=0xCAFE → reads at 0x6000 then 0x7002, load_data=0xCAFE. STI uses the same pointer path and writes sdata to 0x7002.
- DONE held with wb_load=0 for 3 cycles → no new request and memstall=0. wb_load=1 → IDLE.
- reset asserted in ACC2 → read drops immediately, state=IDLE, memstall=0; a following resp pulse causes no capture.

Source files
------------

// File: rtl/lc3b_types.sv
// ============================================================================
// Package  : lc3b_types
// Brief    : LC-3b opcode encoding, MEM-stage sequencer states and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldw  = 4'b0110,
    op_stw  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } mem_ctrl_state_t;

  localparam logic [1:0] c_be_word = 2'b11;
  localparam logic [1:0] c_be_lo   = 2'b01;
  localparam logic [1:0] c_be_hi   = 2'b10;

  function automatic logic is_mem_op(input lc3b_opcode op);
    return op inside {op_ldb, op_ldw, op_ldi, op_stb, op_stw, op_sti};
  endfunction

  function automatic logic is_indirect(input lc3b_opcode op);
    return op inside {op_ldi, op_sti};
  endfunction

  function automatic logic is_load(input lc3b_opcode op);
    return op inside {op_ldb, op_ldw, op_ldi};
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return op inside {op_ldb, op_stb};
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_align.sv
// ============================================================================
// Module   : byte_lane_align
// Brief    : Byte-lane steering: store replication, byte enables, LDB extract.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_align
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  lc3b_opcode            i_op,
  input  logic                  i_byte_sel,
  input  logic [DATA_WIDTH-1:0] i_sdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [1:0]            o_byte_en,
  output logic [DATA_WIDTH-1:0] o_ldb_data
);

  logic [7:0] w_sel_byte;

  // STB replicates the low byte so either lane carries it; the enable picks one.
  always_comb begin
    o_wdata = i_sdata;
    if (i_op == op_stb) begin
      o_wdata = {i_sdata[7:0], i_sdata[7:0]};
    end
  end

  always_comb begin
    o_byte_en = c_be_word;
    if (is_byte_op(i_op)) begin
      o_byte_en = i_byte_sel ? c_be_hi : c_be_lo;
    end
  end

  assign w_sel_byte = i_byte_sel ? i_rdata[DATA_WIDTH-1 -: 8] : i_rdata[7:0];
  assign o_ldb_data = {{(DATA_WIDTH-8){w_sel_byte[7]}}, w_sel_byte};

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : LC-3b MEM-stage sequencer issuing one or two data-memory accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  lc3b_opcode            mem_opcode,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_sdata,
  input  logic                  wb_load,
  input  logic                  dmem_resp,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [DATA_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  output logic                  memstall,
  output logic [DATA_WIDTH-1:0] load_data
);

  localparam logic [DATA_WIDTH-1:0] c_word_mask = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  mem_ctrl_state_t       r_state;
  lc3b_opcode            r_op;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_sdata;
  logic [DATA_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_flush;

  logic                  w_mem_op;
  logic                  w_indirect;
  logic                  w_load;
  logic                  w_byte_op;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ldb_data;
  logic [DATA_WIDTH-1:0] w_capture;
  logic [1:0]            w_lane_be;

  assign w_mem_op   = mem_valid & is_mem_op(mem_opcode);
  assign w_indirect = is_indirect(r_op);
  assign w_load     = is_load(r_op);
  assign w_byte_op  = is_byte_op(r_op);
  // A flush seen at any point of the access retires it without going further.
  assign w_abort    = r_flush | ~mem_valid;

  byte_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_lane_align (
    .i_op       (r_op),
    .i_byte_sel (r_addr[0]),
    .i_sdata    (r_sdata),
    .i_rdata    (dmem_rdata),
    .o_wdata    (w_wdata),
    .o_byte_en  (w_lane_be),
    .o_ldb_data (w_ldb_data)
  );

  assign w_capture = (r_op == op_ldb) ? w_ldb_data : dmem_rdata;

  // Instruction attributes are latched on entry so a flushed access completes intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= op_br;
      r_addr      <= '0;
      r_sdata     <= '0;
      r_ptr       <= '0;
      r_load_data <= '0;
      r_flush     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_flush <= 1'b0;
          if (w_mem_op) begin
            r_op    <= mem_opcode;
            r_addr  <= mem_addr;
            r_sdata <= mem_sdata;
            r_state <= ST_ACC1;
          end
        end
        ST_ACC1: begin
          if (!mem_valid) begin
            r_flush <= 1'b1;
          end
          if (dmem_resp) begin
            if (w_abort) begin
              r_state <= ST_IDLE;
            end else if (w_indirect) begin
              r_ptr   <= dmem_rdata;
              r_state <= ST_ACC2;
            end else begin
              if (w_load) begin
                r_load_data <= w_capture;
              end
              r_state <= ST_DONE;
            end
          end
        end
        ST_ACC2: begin
          if (!mem_valid) begin
            r_flush <= 1'b1;
          end
          if (dmem_resp) begin
            if (w_abort) begin
              r_state <= ST_IDLE;
            end else begin
              if (r_op == op_ldi) begin
                r_load_data <= dmem_rdata;
              end
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (wb_load) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = r_addr & c_word_mask;
    dmem_byte_enable = c_be_word;
    dmem_wdata       = w_wdata;
    case (r_state)
      ST_ACC1: begin
        // Indirect ops always fetch the pointer first, even for STI.
        dmem_read        = w_load | w_indirect;
        dmem_write       = ~(w_load | w_indirect);
        dmem_address     = w_byte_op ? r_addr : (r_addr & c_word_mask);
        dmem_byte_enable = w_lane_be;
      end
      ST_ACC2: begin
        dmem_read    = (r_op == op_ldi);
        dmem_write   = (r_op == op_sti);
        dmem_address = r_ptr & c_word_mask;
      end
      default: begin
      end
    endcase
  end

  assign memstall  = w_mem_op & (r_state != ST_DONE);
  assign load_data = r_load_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Vector table, corner sequences and randomized ops vs. a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  lc3b_opcode  mem_opcode;
  logic [15:0] mem_addr;
  logic [15:0] mem_sdata;
  logic        wb_load;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        memstall;
  logic [15:0] load_data;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_valid        (mem_valid),
    .mem_opcode       (mem_opcode),
    .mem_addr         (mem_addr),
    .mem_sdata        (mem_sdata),
    .wb_load          (wb_load),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .memstall         (memstall),
    .load_data        (load_data)
  );

  typedef struct {
    lc3b_opcode  op;
    logic [15:0] addr, sdata, rd1, rd2;
    int          lat;
    int          nacc;
    logic        wr1;
    logic [15:0] a1;
    logic [1:0]  be1;
    logic [15:0] wd1;
    logic        wr2;
    logic [15:0] a2;
    logic [15:0] wd2;
    logic [15:0] ld;
    int          stall;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_load;

  int          log_n, log_stall, log_conflict;
  bit          log_timeout;
  logic        log_wr[2];
  logic [15:0] log_a[2];
  logic [1:0]  log_be[2];
  logic [15:0] log_wd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expectations from the access rules with plain arithmetic.
  function automatic vec_t model(input lc3b_opcode op, input logic [15:0] addr, sdata,
                                 rd1, rd2, input int lat);
    vec_t v;
    bit   ind, byt;
    logic [15:0] b;
    ind = (op == op_ldi) || (op == op_sti);
    byt = (op == op_ldb) || (op == op_stb);
    v.op = op; v.addr = addr; v.sdata = sdata; v.rd1 = rd1; v.rd2 = rd2; v.lat = lat;
    v.nacc = ind ? 2 : 1;
    v.wr1  = (op == op_stb) || (op == op_stw);
    v.a1   = byt ? addr : (addr / 2) * 2;
    v.be1  = !byt ? 2'd3 : ((addr % 2) == 1 ? 2'd2 : 2'd1);
    v.wd1  = (op == op_stb) ? (sdata % 256) * 257 : sdata;
    v.wr2  = (op == op_sti);
    v.a2   = (rd1 / 2) * 2;
    v.wd2  = sdata;
    b      = ((addr % 2) == 1) ? rd1 / 256 : rd1 % 256;
    case (op)
      op_ldw:  v.ld = rd1;
      op_ldi:  v.ld = rd2;
      op_ldb:  v.ld = (b >= 128) ? b + 16'hFF00 : b;
      default: v.ld = 16'h0;
    endcase
    v.stall = 1 + v.nacc * lat;
    return v;
  endfunction

  // Presents one instruction and plays the memory until memstall falls.
  task automatic run_op(input vec_t v);
    int rc;
    @(negedge clk);
    mem_valid = 1'b1; mem_opcode = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
    wb_load = 1'b0;
    log_n = 0; rc = 0; log_stall = 0; log_conflict = 0; log_timeout = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      if (dmem_read && dmem_write) log_conflict++;
      if (dmem_read || dmem_write) begin
        if (rc == 0) begin
          if (log_n < 2) begin
            log_wr[log_n] = dmem_write;
            log_a[log_n]  = dmem_address;
            log_be[log_n] = dmem_byte_enable;
            log_wd[log_n] = dmem_wdata;
          end
          log_n++;
        end
        rc++;
        if (rc >= v.lat) begin
          dmem_resp  = 1'b1;
          dmem_rdata = (log_n <= 1) ? v.rd1 : v.rd2;
          rc = 0;
        end
      end
      #1;
      if (memstall) log_stall++;
      else if (log_stall > 0) begin
        log_timeout = 1'b0;
        break;
      end
    end
    dmem_resp = 1'b0;
  endtask

  task automatic verify_op(input vec_t v, input string tag);
    check({tag, " timeout"}, 32'(log_timeout), 0);
    check({tag, " stall_cycles"}, log_stall, v.stall);
    check({tag, " accesses"}, log_n, v.nacc);
    check({tag, " rw_conflict"}, log_conflict, 0);
    check({tag, " wr1"}, 32'(log_wr[0]), 32'(v.wr1));
    check({tag, " addr1"}, 32'(log_a[0]), 32'(v.a1));
    check({tag, " be1"}, 32'(log_be[0]), 32'(v.be1));
    if (v.wr1) check({tag, " wdata1"}, 32'(log_wd[0]), 32'(v.wd1));
    if (v.nacc > 1 && log_n > 1) begin
      check({tag, " wr2"}, 32'(log_wr[1]), 32'(v.wr2));
      check({tag, " addr2"}, 32'(log_a[1]), 32'(v.a2));
      check({tag, " be2"}, 32'(log_be[1]), 3);
      if (v.wr2) check({tag, " wdata2"}, 32'(log_wd[1]), 32'(v.wd2));
    end
    if (v.op == op_ldb || v.op == op_ldw || v.op == op_ldi) model_load = v.ld;
    check({tag, " load_data"}, 32'(load_data), 32'(model_load));
    check({tag, " done_req"}, {30'd0, dmem_read, dmem_write}, 0);
  endtask

  // Holds DONE for a number of cycles, then retires via wb_load.
  task automatic finish_op(input int hold, input string tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      check({tag, " hold_req"}, {30'd0, dmem_read, dmem_write}, 0);
      check({tag, " hold_stall"}, 32'(memstall), 0);
    end
    @(negedge clk); wb_load = 1'b1;
    @(negedge clk); wb_load = 1'b0; mem_valid = 1'b0; #1;
    check({tag, " idle_after_wb"}, {30'd0, dmem_read, dmem_write, memstall}, 0);
  endtask

  initial begin
    vec_t       tbl[8];
    vec_t       v;
    lc3b_opcode ops[6];
    ops = '{op_ldb, op_ldw, op_ldi, op_stb, op_stw, op_sti};

    reset = 1'b1; mem_valid = 1'b0; mem_opcode = op_br; mem_addr = '0; mem_sdata = '0;
    wb_load = 1'b0; dmem_resp = 1'b0; dmem_rdata = '0; model_load = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset read", 32'(dmem_read), 0);
    check("reset write", 32'(dmem_write), 0);
    check("reset memstall", 32'(memstall), 0);
    check("reset load_data", 32'(load_data), 0);
    @(negedge clk); reset = 1'b0;

    //        op      addr      sdata     rd1       rd2       lat nacc wr1 a1        be1    wd1       wr2 a2        wd2       ld        stall
    tbl[0] = '{op_ldw, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 2, 1, 1'b0, 16'h3000, 2'b11, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 3};
    tbl[1] = '{op_ldb, 16'h4001, 16'h0000, 16'h80AA, 16'h0000, 1, 1, 1'b0, 16'h4001, 2'b10, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hFF80, 2};
    tbl[2] = '{op_ldb, 16'h4000, 16'h0000, 16'h807F, 16'h0000, 1, 1, 1'b0, 16'h4000, 2'b01, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h007F, 2};
    tbl[3] = '{op_stb, 16'h5001, 16'h1234, 16'h0000, 16'h0000, 1, 1, 1'b1, 16'h5001, 2'b10, 16'h3434, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2};
    tbl[4] = '{op_ldi, 16'h6000, 16'h0000, 16'h7003, 16'hCAFE, 1, 2, 1'b0, 16'h6000, 2'b11, 16'h0000, 1'b0, 16'h7002, 16'h0000, 16'hCAFE, 3};
    tbl[5] = '{op_sti, 16'h6000, 16'h5A5A, 16'h7003, 16'h0000, 1, 2, 1'b0, 16'h6000, 2'b11, 16'h0000, 1'b1, 16'h7002, 16'h5A5A, 16'h0000, 3};
    tbl[6] = '{op_stw, 16'h2003, 16'h9876, 16'h0000, 16'h0000, 3, 1, 1'b1, 16'h2002, 2'b11, 16'h9876, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4};
    tbl[7] = '{op_ldi, 16'h1235, 16'h0000, 16'h0F0F, 16'h1357, 2, 2, 1'b0, 16'h1234, 2'b11, 16'h0000, 1'b0, 16'h0F0E, 16'h0000, 16'h1357, 5};

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i]);
      verify_op(tbl[i], $sformatf("vec%0d", i));
      finish_op(0, $sformatf("vec%0d", i));
    end

    // DONE held by a downstream stall.
    run_op(tbl[0]);
    verify_op(tbl[0], "hold");
    finish_op(3, "hold");

    // Valid non-memory instruction never stalls or requests.
    @(negedge clk); mem_valid = 1'b1; mem_opcode = op_add; #1;
    check("nonmem stall", 32'(memstall), 0);
    @(negedge clk); #1;
    check("nonmem req", {30'd0, dmem_read, dmem_write}, 0);
    mem_valid = 1'b0;

    // Flush during the pointer fetch of LDI: finish the read, skip ACC2.
    @(negedge clk); mem_valid = 1'b1; mem_opcode = op_ldi; mem_addr = 16'h6000; #1;
    check("flush idle stall", 32'(memstall), 1);
    @(negedge clk); mem_valid = 1'b0; #1;
    check("flush acc1 read", 32'(dmem_read), 1);
    check("flush stall low", 32'(memstall), 0);
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'h7003;
    @(negedge clk); dmem_resp = 1'b0; #1;
    check("flush no acc2", {30'd0, dmem_read, dmem_write}, 0);
    @(negedge clk); #1;
    check("flush still idle", {30'd0, dmem_read, dmem_write}, 0);
    check("flush load_data", 32'(load_data), 32'(model_load));

    // Reset while the second LDI access is outstanding.
    @(negedge clk); mem_valid = 1'b1; mem_opcode = op_ldi; mem_addr = 16'h6000;
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'h7003;
    @(negedge clk); dmem_resp = 1'b0; #1;
    check("acc2 read", 32'(dmem_read), 1);
    check("acc2 addr", 32'(dmem_address), 32'h7002);
    #2; reset = 1'b1; mem_valid = 1'b0; #1;
    check("rst acc2 read", 32'(dmem_read), 0);
    check("rst acc2 stall", 32'(memstall), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'h1111;
    @(negedge clk); dmem_resp = 1'b0; #1;
    model_load = 16'h0;
    check("late resp req", {30'd0, dmem_read, dmem_write}, 0);
    check("late resp load", 32'(load_data), 32'(model_load));

    for (int i = 0; i < 120; i++) begin
      v = model(ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), int'($urandom_range(1, 3)));
      run_op(v);
      verify_op(v, $sformatf("rnd%0d", i));
      finish_op(int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
